// File: rtl/text_overlay.sv
// Character-cell text overlay: buffer lookup, font ROM addressing and a 2-cycle pixel pipeline.
// Optional cursor blinking is enabled by defining CURSOR_BLINK_EN.
module text_overlay #(
    parameter int COLS         = 40,
    parameter int ROWS         = 4,
    parameter int X0           = 0,
    parameter int Y0           = 0,
    parameter int SCALE_LOG2   = 0,
    parameter int CW           = 10,
    parameter int AW           = 8,
    parameter int BLINK_FRAMES = 30
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CW-1:0] px_x,
    input  logic [CW-1:0] px_y,
    input  logic          px_de,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_char,
    input  logic          clr,
    output logic          busy,
    output logic [7:0]    font_char,
    output logic [2:0]    font_row,
    input  logic [7:0]    font_bits,
    output logic          pix_on,
    output logic          de_out,
    input  logic          frame_start,
    input  logic [AW-1:0] cursor_addr
);

    localparam int NCELLS = COLS * ROWS;
    localparam int SH     = 3 + SCALE_LOG2;
    localparam logic [CW:0]   X_LO   = (CW+1)'(X0);
    localparam logic [CW:0]   X_HI   = (CW+1)'(X0 + ((COLS * 8) << SCALE_LOG2));
    localparam logic [CW:0]   Y_LO   = (CW+1)'(Y0);
    localparam logic [CW:0]   Y_HI   = (CW+1)'(Y0 + ((ROWS * 8) << SCALE_LOG2));
    localparam logic [AW:0]   NC_A   = (AW+1)'(NCELLS);
    localparam logic [AW-1:0] LAST   = AW'(NCELLS - 1);
    localparam logic [AW-1:0] COLS_A = AW'(COLS);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;

    logic [7:0]    mem [NCELLS];
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [7:0]    mem_wdata;

    logic [CW-1:0] rx, ry;
    logic          in_reg;
    logic [AW-1:0] col, crow, rd_addr;
    logic [2:0]    gx, gy;

    logic [7:0]    char_q;
    logic [2:0]    gx_q, gy_q;
    logic          in_q, de_q;
    logic          glyph_bit;
    logic          invert;

    // Stage 0: map the pixel onto a cell and a glyph position
    assign rx      = px_x - CW'(X0);
    assign ry      = px_y - CW'(Y0);
    assign in_reg  = px_de && ({1'b0, px_x} >= X_LO) && ({1'b0, px_x} < X_HI)
                           && ({1'b0, px_y} >= Y_LO) && ({1'b0, px_y} < Y_HI);
    assign col     = AW'(rx >> SH);
    assign crow    = AW'(ry >> SH);
    assign rd_addr = in_reg ? (crow * COLS_A + col) : '0;
    assign gx      = rx[SCALE_LOG2 +: 3];
    assign gy      = ry[SCALE_LOG2 +: 3];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // A clr pulse always restarts the sweep from cell 0, even mid-sweep
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (clr) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            CLEAR: begin
                if (clr) begin
                    ptr_d = '0;
                end else if (ptr_q == LAST) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            default: begin
                state_d = CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    assign busy = (state_q == CLEAR);

    // The sweep owns the write port; external writes during it are simply lost
    always_comb begin
        mem_we    = wr_en && ({1'b0, wr_addr} < NC_A);
        mem_waddr = wr_addr;
        mem_wdata = wr_char;
        if (state_q == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = ptr_q;
            mem_wdata = 8'd32;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            char_q <= '0;
            gx_q   <= '0;
            gy_q   <= '0;
            in_q   <= 1'b0;
            de_q   <= 1'b0;
        end else begin
            char_q <= mem[rd_addr];
            gx_q   <= gx;
            gy_q   <= gy;
            in_q   <= in_reg;
            de_q   <= px_de;
        end
    end

    assign font_char = char_q;
    assign font_row  = gy_q;
    assign glyph_bit = font_bits[3'd7 - gx_q];

`ifdef CURSOR_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [FW-1:0] fcnt_q;
    logic          blink_q;
    logic [AW-1:0] cell_q, cur_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fcnt_q  <= '0;
            blink_q <= 1'b0;
        end else if (frame_start) begin
            if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
                fcnt_q  <= '0;
                blink_q <= ~blink_q;
            end else begin
                fcnt_q <= fcnt_q + 1'b1;
            end
        end
    end

    // Cursor cell travels with the read address so the compare lines up with char_q
    always_ff @(posedge clk) begin
        if (reset) begin
            cell_q <= '0;
            cur_q  <= '0;
        end else begin
            cell_q <= rd_addr;
            cur_q  <= cursor_addr;
        end
    end

    assign invert = blink_q && (cell_q == cur_q);
`else
    logic unused_cursor;
    assign unused_cursor = ^{frame_start, cursor_addr, (BLINK_FRAMES > 0)};
    assign invert        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_on <= 1'b0;
            de_out <= 1'b0;
        end else begin
            pix_on <= in_q & (glyph_bit ^ invert);
            de_out <= de_q;
        end
    end

endmodule

// File: tb/tb_text_overlay.sv
// Self-checking bench for text_overlay: two instances (1x and 2x glyph scale) on a shared pixel stream.
module tb_text_overlay;

    localparam int COLS   = 40;
    localparam int ROWS   = 4;
    localparam int X0     = 8;
    localparam int Y0     = 4;
    localparam int CW     = 10;
    localparam int AW     = 8;
    localparam int NCELLS = COLS * ROWS;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [CW-1:0] px_x = '0;
    logic [CW-1:0] px_y = '0;
    logic          px_de = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [7:0]    wr_char = '0;
    logic          clr = 1'b0;
    logic          frame_start = 1'b0;
    logic [AW-1:0] cursor_addr = '0;

    logic       busy0, busy1;
    logic [7:0] font_char0, font_char1, font_bits0, font_bits1;
    logic [2:0] font_row0, font_row1;
    logic       pix0, pix1, de0, de1;

    typedef struct {
        logic  p0;
        logic  p1;
        logic  de;
        bit    chk;
        string tag;
    } exp_t;

    typedef struct {
        int   x;
        int   y;
        logic de;
        logic p0;
        logic p1;
    } vec_t;

    exp_t       sb[$];
    vec_t       vecs[20];
    logic [7:0] exp_mem [NCELLS];
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    text_overlay #(.COLS(COLS), .ROWS(ROWS), .X0(X0), .Y0(Y0), .SCALE_LOG2(0),
                   .CW(CW), .AW(AW), .BLINK_FRAMES(2)) dut (
        .clk(clk), .reset(reset), .px_x(px_x), .px_y(px_y), .px_de(px_de),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char), .clr(clr), .busy(busy0),
        .font_char(font_char0), .font_row(font_row0), .font_bits(font_bits0),
        .pix_on(pix0), .de_out(de0), .frame_start(frame_start), .cursor_addr(cursor_addr)
    );

    text_overlay #(.COLS(COLS), .ROWS(ROWS), .X0(X0), .Y0(Y0), .SCALE_LOG2(1),
                   .CW(CW), .AW(AW), .BLINK_FRAMES(2)) dut2 (
        .clk(clk), .reset(reset), .px_x(px_x), .px_y(px_y), .px_de(px_de),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char), .clr(clr), .busy(busy1),
        .font_char(font_char1), .font_row(font_row1), .font_bits(font_bits1),
        .pix_on(pix1), .de_out(de1), .frame_start(frame_start), .cursor_addr(cursor_addr)
    );

    // Small font: blank space, a real 'A', and an arbitrary non-blank pattern otherwise
    function automatic logic [7:0] font_rom(input logic [7:0] c, input logic [2:0] r);
        if (c == 8'd32) return 8'h00;
        if (c == 8'd65) begin
            case (r)
                3'd0: return 8'b00011000;
                3'd1: return 8'b00111100;
                3'd2: return 8'b01100110;
                3'd3: return 8'b01100110;
                3'd4: return 8'b01111110;
                3'd5: return 8'b01100110;
                3'd6: return 8'b01100110;
                default: return 8'b00000000;
            endcase
        end
        return c ^ {r, 5'h15};
    endfunction

    assign font_bits0 = font_rom(font_char0, font_row0);
    assign font_bits1 = font_rom(font_char1, font_row1);

    function automatic logic exp_pix(input int x, input int y, input logic de, input int s);
        int         w, rx, ry, gx, gy;
        logic [7:0] bits;
        w  = 8 * (1 << s);
        rx = x - X0;
        ry = y - Y0;
        if (!de || rx < 0 || ry < 0 || rx >= COLS * w || ry >= ROWS * w) return 1'b0;
        gx   = (rx % w) / (1 << s);
        gy   = (ry % w) / (1 << s);
        bits = font_rom(exp_mem[(ry / w) * COLS + (rx / w)], 3'(gy));
        return bits[7 - gx];
    endfunction

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        if (!e.chk) return;
        checks++;
        if ({pix0, pix1, de0, de1} !== {e.p0, e.p1, e.de, e.de}) begin
            failures++;
            $display("[TB] FAIL %s pix_on=%b/%b de_out=%b/%b expected pix_on=%b/%b de_out=%b",
                     e.tag, pix0, pix1, de0, de1, e.p0, e.p1, e.de);
        end
    endtask

    // Called at a negedge; the entry pushed two calls earlier is now at the outputs
    task automatic applyStimulus(input int x, input int y, input logic de, input logic p0,
                                 input logic p1, input bit chk, input string tag);
        exp_t e;
        if (sb.size() == 2) checkOutput(sb.pop_front());
        px_x  = CW'(x);
        px_y  = CW'(y);
        px_de = de;
        e.p0 = p0; e.p1 = p1; e.de = de; e.chk = chk; e.tag = tag;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic flush();
        applyStimulus(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, "");
        applyStimulus(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, "");
        sb.delete();
    endtask

    task automatic scanModel(input int xl, input int xh, input int yl, input int yh, input string tag);
        for (int y = yl; y <= yh; y++)
            for (int x = xl; x <= xh; x++)
                applyStimulus(x, y, 1'b1, exp_pix(x, y, 1'b1, 0), exp_pix(x, y, 1'b1, 1), 1'b1, tag);
        flush();
    endtask

    task automatic writeCell(input int addr, input logic [7:0] ch);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_char = ch;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic checkCells(input string tag);
        for (int a = 0; a < NCELLS; a++) begin
            px_x  = CW'(X0 + (a % COLS) * 8);
            px_y  = CW'(Y0 + (a / COLS) * 8);
            px_de = 1'b1;
            @(negedge clk);
            checkValue($sformatf("%s[%0d]", tag, a), 32'(font_char0), 32'(exp_mem[a]));
        end
        px_de = 1'b0;
    endtask

    task automatic countBusy(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy0 && n < 400);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        vecs[0]  = '{8, 5, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{9, 5, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{10, 5, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{11, 5, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{12, 5, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{13, 5, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{14, 5, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{15, 5, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{12, 6, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{13, 6, 1'b1, 1'b1, 1'b1};
        vecs[10] = '{325, 5, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{327, 5, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{328, 5, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{7, 5, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{13, 5, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{10, 29, 1'b1, 1'b1, 1'b0};
        vecs[16] = '{10, 36, 1'b1, 1'b0, 1'b0};
        vecs[17] = '{10, 3, 1'b1, 1'b0, 1'b0};
        vecs[18] = '{16, 7, 1'b1, 1'b0, 1'b1};
        vecs[19] = '{23, 7, 1'b1, 1'b0, 1'b0};

        // Reset with an active in-region pixel to prove the pipeline is held clear
        reset = 1'b1;
        px_de = 1'b1;
        px_x  = CW'(10);
        px_y  = CW'(5);
        repeat (3) @(negedge clk);
        checkValue("reset_busy", 32'(busy0), 32'd1);
        checkValue("reset_busy2", 32'(busy1), 32'd1);
        checkValue("reset_pix", 32'(pix0), 32'd0);
        checkValue("reset_de", 32'(de0), 32'd0);

        reset = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                checkValue("post_reset_de", 32'({de0, de1}), 32'd0);
                checkValue("post_reset_pix", 32'({pix0, pix1}), 32'd0);
            end
        end while (busy0 && n < 400);
        checkValue("sweep_len", 32'(n), 32'd160);
        checkValue("sweep_done2", 32'(busy1), 32'd0);
        px_de = 1'b0;

        for (int a = 0; a < NCELLS; a++) exp_mem[a] = 8'd32;
        checkCells("clear_cell");
        scanModel(0, 335, 0, 40, "clear_scan");

        writeCell(0, 8'd65);   exp_mem[0]   = 8'd65;
        writeCell(39, 8'd65);  exp_mem[39]  = 8'd65;
        writeCell(120, 8'd65); exp_mem[120] = 8'd65;
        writeCell(200, 8'd90);

        for (int i = 0; i < 20; i++)
            applyStimulus(vecs[i].x, vecs[i].y, vecs[i].de, vecs[i].p0, vecs[i].p1, 1'b1,
                          $sformatf("vec%0d", i));
        flush();

        scanModel(4, 30, 3, 13, "a_scan");
        scanModel(316, 335, 3, 13, "edge_scan");
        scanModel(4, 30, 26, 37, "row3_scan");

        px_x  = CW'(12);
        px_y  = CW'(6);
        px_de = 1'b1;
        @(negedge clk);
        checkValue("font_row_x1", 32'(font_row0), 32'd2);
        checkValue("font_row_x2", 32'(font_row1), 32'd1);
        checkValue("font_char_x2", 32'(font_char1), 32'd65);
        px_de = 1'b0;
        checkCells("after_wr");

        // clr from IDLE, restart at ptr 50, then a dropped write late in the new sweep
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checkValue("clr_busy", 32'(busy0), 32'd1);
        repeat (50) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        n = 0;
        do begin
            wr_en   = (n == 100);
            wr_addr = AW'(5);
            wr_char = 8'd90;
            @(negedge clk);
            n++;
        end while (busy0 && n < 400);
        wr_en = 1'b0;
        checkValue("restart_len", 32'(n), 32'd160);
        for (int a = 0; a < NCELLS; a++) exp_mem[a] = 8'd32;
        checkCells("after_clr");

        // Same-cycle read and write of one cell returns the old character
        px_x    = CW'(X0);
        px_y    = CW'(Y0);
        px_de   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = '0;
        wr_char = 8'd65;
        @(negedge clk);
        wr_en = 1'b0;
        checkValue("rw_old", 32'(font_char0), 32'd32);
        @(negedge clk);
        checkValue("rw_new", 32'(font_char0), 32'd65);
        px_de = 1'b0;
        writeCell(0, 8'd32);

        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (30) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        countBusy(n);
        checkValue("reset_mid_len", 32'(n), 32'd160);

`ifdef CURSOR_BLINK_EN
        cursor_addr = '0;
        for (int f = 0; f < 6; f++) begin
            logic on;
            if (f > 0) begin
                frame_start = 1'b1;
                @(negedge clk);
                frame_start = 1'b0;
            end
            on = (f == 2 || f == 3);
            for (int y = Y0; y < Y0 + 8; y++)
                for (int x = X0; x < X0 + 8; x++)
                    applyStimulus(x, y, 1'b1, on, on, 1'b1, $sformatf("cursor_f%0d", f));
            flush();
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/text_overlay.md
Name: text_overlay

Overview:
- Character-cell text renderer between the VGA timing generator and the pixel colour mux.
- Holds a COLS×ROWS character buffer written by game logic.
- For each incoming pixel coordinate, reads the buffer, drives the 8×8 font ROM (char_code/row in, bits out, purely combinational), and emits a registered per-pixel "text on" flag.
- Also owns buffer clear/initialisation via a small FSM.

Parameters:
COLS, 40, character columns
ROWS, 4, character rows
X0, 0, left pixel of text region
Y0, 0, top pixel of text region
SCALE_LOG2, 0, glyph magnification 2^SCALE_LOG2 (0..2)
CW, 10, pixel coordinate width
AW, 8, buffer address width (COLS*ROWS <= 2^AW)
BLINK_FRAMES, 30, frames per cursor blink half-period (CURSOR_BLINK_EN only)

Ports:
clk  in  1  pixel clock
reset  in  1  synchronous active-high reset
px_x  in  CW  current pixel x
px_y  in  CW  current pixel y
px_de  in  1  display-enable for px_x/px_y
wr_en  in  1  buffer write strobe
wr_addr  in  AW  write address = row*COLS+col
wr_char  in  8  character code to store
clr  in  1  one-cycle pulse: fill buffer with spaces
busy  out  1  clear sweep in progress
font_char  out  8  to font ROM char_code
font_row  out  3  to font ROM row
font_bits  in  8  from font ROM bits (same-cycle combinational)
pix_on  out  1  text foreground at delayed pixel
de_out  out  1  px_de delayed to align with pix_on
frame_start  in  1  one-cycle pulse at start of frame (used only with CURSOR_BLINK_EN)
cursor_addr  in  AW  cursor cell (used only with CURSOR_BLINK_EN)

Behaviour:
- Buffer: COLS*ROWS×8 synchronous-read RAM, no reset of contents.
  - Same-cycle read/write to the same address returns old data.
  - Write with wr_addr >= COLS*ROWS is ignored.
- Stage 0 (comb):
  - rx = px_x - X0, ry = px_y - Y0.
  - in_reg = px_de & px_x>=X0 & px_x<X0+COLS*8<<SCALE_LOG2 & same test for y with ROWS.
  - col = rx>>(3+SCALE_LOG2), crow = ry>>(3+SCALE_LOG2), read addr = crow*COLS+col (don't-care when !in_reg).
  - gy = (ry>>SCALE_LOG2)&7, gx = (rx>>SCALE_LOG2)&7.
- Stage 1 (reg): char_q (RAM output), gy_q, gx_q, in_q, de_q.
  - font_char = char_q; font_row = gy_q (combinational from stage-1 regs).
- Stage 2 (reg):
  - pix_on <= in_q & font_bits[7-gx_q]; de_out <= de_q.
  - Total latency px_* -> pix_on/de_out = 2 cycles, one pixel per cycle, no stalls.
- Clear FSM, states IDLE and CLEAR:
  - reset -> CLEAR with ptr=0.
  - CLEAR: write 8'd32 to buffer[ptr] each cycle, ptr++. After writing COLS*ROWS-1 -> IDLE.
  - IDLE & clr -> CLEAR, ptr=0.
  - clr during CLEAR restarts at ptr=0.
  - busy = (state==CLEAR).
  - External wr_en during CLEAR is dropped (not queued).
  - Clear sweep takes exactly COLS*ROWS cycles.
- Display pipeline runs during CLEAR; it shows whatever the buffer holds.
- Reset values while reset high and the cycle after:
  - pix_on=0, de_out=0, busy=1.
  - Pipeline regs cleared: char_q=0, in_q=0, de_q=0.
- Reset mid-sweep restarts the sweep from 0.

Optional Feature:
- CURSOR_BLINK_EN defined:
  - Frame counter counts frame_start pulses 0..BLINK_FRAMES-1; blink bit toggles on wrap.
  - Reset: counter=0, blink=0.
  - When the stage-1 cell address equals cursor_addr and blink=1, pix_on is the inverse of the glyph bit, still gated by in_q.
  - Cursor addr is pipelined alongside the read address.
- CURSOR_BLINK_EN undefined:
  - No counter or blink logic.
  - frame_start and cursor_addr ports are present but ignored.

Test Plan:
- Reset, hold low 160 cycles (COLS=40, ROWS=4) -> busy=1 for exactly 160 cycles then 0; every buffer cell reads 32; pix_on=0 across the whole region.
- After clear, write wr_addr=0 wr_char=8'd65 ('A'); scan px_y=Y0+1, px_x=X0..X0+7 with px_de=1 -> pix_on two cycles later = 0,0,1,1,1,1,0,0; de_out=1 aligned.
- SCALE_LOG2=1, 'A' at cell 0, px_y=Y0+2 -> font_row=1; pixels x=X0+4,X0+5 both 1 (bits 00111100).
- Pixel at px_x=X0+COLS*8 or px_de=0 with a non-space char at the edge cell -> pix_on=0; de_out follows px_de with 2-cycle delay.
- wr_en during CLEAR at addr 5 char 'Z', and wr_addr=200 when IDLE -> after sweep, cell 5 reads 32; no cell changed by addr 200. clr reasserted at ptr=50 -> busy stays high 160 more cycles.
- CURSOR_BLINK_EN, BLINK_FRAMES=2, cursor_addr=0 with space in cell 0 -> pix_on=0 for frames 0-1, all 64 in-region pixels of the cell =1 for frames 2-3, 0 again for frames 4-5.
